// File: rtl/noc_pkg.sv
// Shared flit geometry for the compute-node ring: field widths, offsets and access helpers.
// Flit layout, MSB->LSB: valid | dest | src | data | instr | pkt_id | seq.
package noc_pkg;

    localparam int unsigned DataWidth       = 16;
    localparam int unsigned InstrWidth      = 3;
    localparam int unsigned SeqWidth        = 2;
    localparam int unsigned MaxFlitWidth    = 64;
    localparam int unsigned MaxNodeBits     = 16;
    localparam int unsigned DefNodeCount    = 16;
    localparam int unsigned DefPktIdWidth   = 5;
    localparam int unsigned DefNodeBits     = 4;

    function automatic int unsigned nodeBits(input int unsigned nodeCount);
        return (nodeCount < 2) ? 1 : $clog2(nodeCount);
    endfunction

    function automatic int unsigned flitWidth(input int unsigned nodeCount,
                                              input int unsigned pktIdWidth);
        return 1 + 2 * nodeBits(nodeCount) + DataWidth + InstrWidth + pktIdWidth + SeqWidth;
    endfunction

    function automatic int unsigned destLsb(input int unsigned nodeCount,
                                            input int unsigned pktIdWidth);
        return SeqWidth + pktIdWidth + InstrWidth + DataWidth + nodeBits(nodeCount);
    endfunction

    // Flit for the default ring geometry (16 nodes, 5-bit packet id).
    typedef struct packed {
        logic                     valid;
        logic [DefNodeBits-1:0]   dest;
        logic [DefNodeBits-1:0]   src;
        logic [DataWidth-1:0]     data;
        logic [InstrWidth-1:0]    instr;
        logic [DefPktIdWidth-1:0] pktId;
        logic [SeqWidth-1:0]      seq;
    } flit_t;

    typedef logic [MaxFlitWidth-1:0] flitBus_t;

    // Helpers take a zero-extended flit so one function serves every geometry.
    function automatic logic flit_valid(input flitBus_t f, input int unsigned fw);
        flitBus_t sh;
        sh = f >> (fw - 1);
        return sh[0];
    endfunction

    function automatic logic [MaxNodeBits-1:0] flit_dest(input flitBus_t f,
                                                         input int unsigned nodeCount,
                                                         input int unsigned pktIdWidth);
        flitBus_t sh;
        logic [MaxNodeBits-1:0] mask;
        sh   = f >> destLsb(nodeCount, pktIdWidth);
        mask = MaxNodeBits'((32'd1 << nodeBits(nodeCount)) - 32'd1);
        return MaxNodeBits'(sh) & mask;
    endfunction

endpackage

// File: rtl/ring_eject_fifo.sv
// Eject FIFO between the ring stop and the node's packet collector.
// Head is read straight from storage, so a push into an empty FIFO is visible the next cycle.
module ring_eject_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushValid,
    output logic             pushReady,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic [WIDTH-1:0] popData
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    always_comb begin
        empty = (wrPtr == rdPtr);
        full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
        pop   = ~empty & popReady;
        // A pop in the same cycle frees the slot the push lands in.
        pushReady = ~full | popReady;
        push      = pushValid & pushReady;
        popData   = empty ? '0 : mem[rdPtr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= pushData;
    end

endmodule

// File: rtl/ring_stop.sv
// One stop of the unidirectional flit ring: ejects flits addressed to this node, forwards the rest,
// and injects local flits into free slots with a starvation guard.
module ring_stop
    import noc_pkg::*;
#(
    parameter int unsigned NODE_ID         = 0,
    parameter int unsigned NODE_COUNT      = 16,
    parameter int unsigned PACKET_ID_WIDTH = 5,
    parameter int unsigned EJECT_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT    = 8,
    localparam int unsigned FW = flitWidth(NODE_COUNT, PACKET_ID_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] ring_in,
    output logic          ring_in_ready,
    output logic [FW-1:0] ring_out,
    input  logic          ring_out_ready,
    input  logic [FW-1:0] inj_flit,
    output logic          inj_ready,
    output logic [FW-1:0] ej_flit,
    input  logic          ej_ready
);

    localparam int unsigned ND = nodeBits(NODE_COUNT);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [FW-1:0] ringOutQ;
    logic [FW-1:0] ringOutD;
    logic [SW-1:0] starveCnt;
    logic [SW-1:0] starveD;

    logic          inValid;
    logic [ND-1:0] inDest;
    logic          isEject;
    logic          isFwd;
    logic          injValid;
    logic          canLoad;
    logic          forceInj;
    logic          fwdXfer;
    logic          injXfer;
    logic          ejPush;
    logic          ejPushReady;

    assign inValid  = flit_valid(MaxFlitWidth'(ring_in), FW);
    assign inDest   = ND'(flit_dest(MaxFlitWidth'(ring_in), NODE_COUNT, PACKET_ID_WIDTH));
    assign injValid = inj_flit[FW-1];

    always_comb begin
        isEject  = inValid && (inDest == ND'(NODE_ID));
        isFwd    = inValid && (inDest != ND'(NODE_ID));
        canLoad  = ~ringOutQ[FW-1] | ring_out_ready;
        forceInj = (starveCnt == SW'(STARVE_LIMIT));

        // Ejection only depends on FIFO space, so a forced inject never blocks it.
        if (rst) begin
            ring_in_ready = 1'b0;
        end else if (isEject) begin
            ring_in_ready = ejPushReady;
        end else begin
            ring_in_ready = canLoad && ~forceInj;
        end
        inj_ready = ~rst && canLoad && (~isFwd || forceInj);

        fwdXfer = isFwd && ring_in_ready;
        injXfer = injValid && inj_ready;
        ejPush  = isEject && ring_in_ready;

        ringOutD = ringOutQ;
        if (canLoad) begin
            if (injXfer) begin
                ringOutD = inj_flit;
            end else if (fwdXfer) begin
                ringOutD = ring_in;
            end else begin
                ringOutD = '0;
            end
        end

        starveD = starveCnt;
        if (injXfer) begin
            starveD = '0;
        end else if (injValid && ~inj_ready && ~forceInj) begin
            starveD = starveCnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ringOutQ  <= '0;
            starveCnt <= '0;
        end else begin
            ringOutQ  <= ringOutD;
            starveCnt <= starveD;
        end
    end

    assign ring_out = ringOutQ;

    ring_eject_fifo #(
        .WIDTH (FW),
        .DEPTH (EJECT_DEPTH)
    ) uEjectFifo (
        .clk       (clk),
        .rst       (rst),
        .pushValid (ejPush),
        .pushReady (ejPushReady),
        .pushData  (ring_in),
        .popReady  (ej_ready),
        .popData   (ej_flit)
    );

    // An out-of-range destination never matches any stop and would circulate forever.
    always_ff @(posedge clk) begin
        if (!rst && inValid) begin
            assert (int'({1'b0, inDest}) < int'(NODE_COUNT));
        end
    end

endmodule

// File: tb/tb_ring_stop.sv
// Bench for ring_stop at NODE_ID=3: vector table, hand-written corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_ring_stop;
    import noc_pkg::*;

    localparam int unsigned FW     = 35;
    localparam int unsigned SELF   = 3;
    localparam int unsigned LIMIT  = 8;
    localparam int unsigned DEPTH  = 4;

    logic          clk;
    logic          rst;
    logic [FW-1:0] ringIn;
    logic          ringInReady;
    logic [FW-1:0] ringOut;
    logic          ringOutReady;
    logic [FW-1:0] injFlit;
    logic          injReady;
    logic [FW-1:0] ejFlit;
    logic          ejReady;

    int passed = 0;
    int total  = 0;

    ring_stop #(
        .NODE_ID         (SELF),
        .NODE_COUNT      (16),
        .PACKET_ID_WIDTH (5),
        .EJECT_DEPTH     (DEPTH),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ring_in        (ringIn),
        .ring_in_ready  (ringInReady),
        .ring_out       (ringOut),
        .ring_out_ready (ringOutReady),
        .inj_flit       (injFlit),
        .inj_ready      (injReady),
        .ej_flit        (ejFlit),
        .ej_ready       (ejReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [FW-1:0] mk(input int unsigned dest, input logic [15:0] data);
        flit_t f;
        f       = '0;
        f.valid = 1'b1;
        f.dest  = 4'(dest);
        f.src   = data[3:0];
        f.data  = data;
        f.instr = data[6:4];
        f.pktId = data[11:7];
        f.seq   = data[13:12];
        return f;
    endfunction

    task automatic chkF(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chkB(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ringIn = '0;
        injFlit = '0;
        ringOutReady = 1'b1;
        ejReady = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [FW-1:0] rin;
        logic [FW-1:0] inj;
        logic          ror;
        logic          chkRir;
        logic          expRir;
        logic          expInjr;
        logic [FW-1:0] expOut;
        logic [FW-1:0] expEj;
    } vec_t;

    vec_t vecs[8];

    // Reference model state
    logic [FW-1:0] mq[$];
    logic [FW-1:0] mRo;
    int unsigned   mStarve;

    initial begin
        logic [FW-1:0] fa, fs, fi, fb;
        int unsigned f;

        rst = 1'b1;
        ringIn = '0;
        injFlit = '0;
        ringOutReady = 1'b1;
        ejReady = 1'b1;

        fa = mk(5, 16'h1234);
        fs = mk(SELF, 16'hBEEF);
        fi = mk(11, 16'h0C0D);
        vecs[0] = '{fa, '0, 1'b1, 1'b1, 1'b1, 1'b0, fa, '0};
        vecs[1] = '{fs, '0, 1'b1, 1'b1, 1'b1, 1'b1, '0, fs};
        vecs[2] = '{'0, fi, 1'b1, 1'b0, 1'b0, 1'b1, fi, '0};
        vecs[3] = '{fa, fi, 1'b1, 1'b1, 1'b1, 1'b0, fa, '0};
        vecs[4] = '{fs, fi, 1'b1, 1'b1, 1'b1, 1'b1, fi, fs};
        vecs[5] = '{fa, '0, 1'b0, 1'b1, 1'b1, 1'b0, fa, '0};
        vecs[6] = '{mk(0, 16'h0F00), '0, 1'b1, 1'b1, 1'b1, 1'b0, mk(0, 16'h0F00), '0};
        vecs[7] = '{mk(15, 16'hF00F), '0, 1'b1, 1'b1, 1'b1, 1'b0, mk(15, 16'hF00F), '0};

        // Reset cycle: readies low even with valid traffic offered
        @(negedge clk);
        ringIn = fa;
        injFlit = fi;
        #1;
        chkB("reset ring_in_ready", ringInReady, 1'b0);
        chkB("reset inj_ready", injReady, 1'b0);
        @(posedge clk);
        #1;
        chkF("reset ring_out", ringOut, '0);
        chkF("reset ej_flit", ejFlit, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            doReset();
            @(negedge clk);
            ringIn = vecs[i].rin;
            injFlit = vecs[i].inj;
            ringOutReady = vecs[i].ror;
            ejReady = 1'b1;
            #1;
            if (vecs[i].chkRir) chkB($sformatf("vec%0d ring_in_ready", i), ringInReady, vecs[i].expRir);
            chkB($sformatf("vec%0d inj_ready", i), injReady, vecs[i].expInjr);
            @(posedge clk);
            #1;
            chkF($sformatf("vec%0d ring_out", i), ringOut, vecs[i].expOut);
            chkF($sformatf("vec%0d ej_flit", i), ejFlit, vecs[i].expEj);
        end
        doReset();
        chkB("beef data", ejFlit[25:10] == 16'hBEEF, 1'b0);

        // Forward throughput: one flit per cycle
        doReset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ringIn = mk(5, 16'h2000 + 16'(k));
            #1 chkB("thru ring_in_ready", ringInReady, 1'b1);
            @(posedge clk);
            #1 chkF("thru ring_out", ringOut, mk(5, 16'h2000 + 16'(k)));
        end

        // Eject FIFO fill, back-pressure and same-cycle push/pop
        doReset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ringIn = mk(SELF, 16'h3000 + 16'(k));
            ejReady = 1'b0;
            #1 chkB("fill accept", ringInReady, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        ringIn = mk(SELF, 16'h3004);
        #1;
        chkB("full ring_in_ready", ringInReady, 1'b0);
        chkF("full head", ejFlit, mk(SELF, 16'h3000));
        @(posedge clk);
        @(negedge clk);
        ejReady = 1'b1;
        #1 chkB("pop frees slot", ringInReady, 1'b1);
        @(posedge clk);
        #1 chkF("order head1", ejFlit, mk(SELF, 16'h3001));
        @(negedge clk);
        ringIn = '0;
        for (int k = 2; k < 5; k++) begin
            @(posedge clk);
            #1 chkF($sformatf("order head%0d", k), ejFlit, mk(SELF, 16'h3000 + 16'(k)));
        end
        @(posedge clk);
        #1 chkF("drained", ejFlit, '0);

        // Starvation: forced inject on cycle LIMIT+1, upstream held exactly one cycle
        doReset();
        f = 0;
        fi = mk(7, 16'h1717);
        for (int c = 1; c <= int'(LIMIT) + 3; c++) begin
            @(negedge clk);
            injFlit = (c <= int'(LIMIT) + 1) ? fi : '0;
            ringIn = mk(5, 16'h4000 + 16'(f));
            #1;
            chkB($sformatf("starve inj_ready c%0d", c), injReady, c == int'(LIMIT) + 1);
            chkB($sformatf("starve ring_in_ready c%0d", c), ringInReady, c != int'(LIMIT) + 1);
            @(posedge clk);
            #1;
            if (c == int'(LIMIT) + 1) begin
                chkF("starve inj out", ringOut, fi);
            end else begin
                chkF($sformatf("starve fwd out c%0d", c), ringOut, mk(5, 16'h4000 + 16'(f)));
                f++;
            end
        end

        // Downstream stall holds ring_out and blocks both sources
        doReset();
        fa = mk(9, 16'h5A5A);
        fb = mk(10, 16'h6B6B);
        @(negedge clk);
        ringIn = fa;
        @(posedge clk);
        @(negedge clk);
        ringIn = fb;
        injFlit = mk(12, 16'h7C7C);
        ringOutReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chkB("stall ring_in_ready", ringInReady, 1'b0);
            chkB("stall inj_ready", injReady, 1'b0);
            @(posedge clk);
            #1 chkF("stall ring_out", ringOut, fa);
            @(negedge clk);
        end
        ringOutReady = 1'b1;
        #1 chkB("unstall ring_in_ready", ringInReady, 1'b1);
        @(posedge clk);
        #1 chkF("unstall ring_out", ringOut, fb);

        // Reset mid-operation
        doReset();
        ejReady = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            ringIn = mk(SELF, 16'h8000 + 16'(k));
            ejReady = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        ringIn = mk(4, 16'h8100);
        @(posedge clk);
        @(negedge clk);
        #1;
        chkF("pre-reset head", ejFlit, mk(SELF, 16'h8000));
        chkF("pre-reset ring_out", ringOut, mk(4, 16'h8100));
        rst = 1'b1;
        injFlit = mk(6, 16'h8200);
        ringIn = mk(4, 16'h8101);
        #1;
        chkB("mid reset ring_in_ready", ringInReady, 1'b0);
        chkB("mid reset inj_ready", injReady, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ringIn = '0;
        injFlit = '0;
        ejReady = 1'b1;
        chkF("post reset ring_out", ringOut, '0);
        chkF("post reset ej_flit", ejFlit, '0);
        @(posedge clk);
        #1 chkF("post reset fifo empty", ejFlit, '0);

        // Random traffic against the reference model
        doReset();
        mq.delete();
        mRo = '0;
        mStarve = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flit_t       rf;
            logic        canLoad, force_, isEj, isFwd, eRir, eInjr, pop, injV;
            logic [FW-1:0] head;
            @(negedge clk);
            if ($urandom_range(0, 9) < 7) begin
                ringIn = mk(($urandom_range(0, 2) == 0) ? SELF : $urandom_range(0, 15),
                            16'($urandom));
            end else begin
                ringIn = '0;
            end
            injFlit = ($urandom_range(0, 1) == 1) ? mk($urandom_range(0, 15), 16'($urandom)) : '0;
            ringOutReady = ($urandom_range(0, 3) != 0);
            ejReady = ($urandom_range(0, 4) < 3);
            #1;
            rf      = ringIn;
            injV    = injFlit[FW-1];
            canLoad = !mRo[FW-1] || ringOutReady;
            force_  = (mStarve == LIMIT);
            isEj    = rf.valid && (rf.dest == 4'(SELF));
            isFwd   = rf.valid && (rf.dest != 4'(SELF));
            pop     = (mq.size() > 0) && ejReady;
            if (isEj) eRir = (mq.size() < DEPTH) || pop;
            else      eRir = canLoad && !force_;
            eInjr   = canLoad && (!isFwd || force_);
            if (rf.valid) chkB("rand ring_in_ready", ringInReady, eRir);
            chkB("rand inj_ready", injReady, eInjr);
            if (pop) void'(mq.pop_front());
            if (isEj && eRir) mq.push_back(ringIn);
            if (canLoad) begin
                if (injV && eInjr)          mRo = injFlit;
                else if (isFwd && eRir)     mRo = ringIn;
                else                        mRo = '0;
            end
            if (injV && eInjr)                        mStarve = 0;
            else if (injV && !eInjr && mStarve < LIMIT) mStarve++;
            head = (mq.size() > 0) ? mq[0] : '0;
            @(posedge clk);
            #1;
            chkF("rand ring_out", ringOut, mRo);
            chkF("rand ej_flit", ejFlit, head);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
